// File: rtl/seg_byte_monitor.sv
// Multi-channel byte monitor: per-channel circular history buffers shown on a
// multiplexed 2*NUM_CH-digit active-low seven-segment display.
module seg_byte_monitor #(
  parameter int NUM_CH      = 2,
  parameter int DEPTH       = 4,
  parameter int DIV         = 262144,
  parameter int FLASH_TICKS = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          ch_valid,
  input  logic [8*NUM_CH-1:0]        ch_data,
  input  logic [$clog2(DEPTH)-1:0]   hist_sel,
  input  logic                       freeze,
  input  logic                       clear,
  output logic [6:0]                 seg,
  output logic                       dp,
  output logic [2*NUM_CH-1:0]        an,
  output logic [NUM_CH-1:0]          overflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int DW  = $clog2(DIV);
  localparam int ND  = 2 * NUM_CH;
  localparam int SW  = $clog2(ND);
  localparam int FW  = $clog2(FLASH_TICKS + 1);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      4'hF: hex7 = 7'h0E;
      default: hex7 = 7'h7F;
    endcase
  endfunction

  logic [DW-1:0]  div_r;
  logic           tick_s;
  logic [SW-1:0]  scan_r;
  logic [SW-1:0]  scan_nxt_s;
  logic [7:0]     show_s     [NUM_CH];
  logic           blank_s    [NUM_CH];
  logic           flash_on_s [NUM_CH];
  logic [CHW-1:0] sel_ch_s;
  logic [3:0]     nib_s;

  assign tick_s = (div_r == DW'(DIV - 1));

  // Free-running refresh divider, independent of clear and freeze.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_r <= {DW{1'b0}};
    end else if (tick_s) begin
      div_r <= {DW{1'b0}};
    end else begin
      div_r <= div_r + DW'(1);
    end
  end

  always_comb begin
    if (scan_r == SW'(ND - 1)) begin
      scan_nxt_s = {SW{1'b0}};
    end else begin
      scan_nxt_s = scan_r + SW'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [7:0]    buf_r [DEPTH];
    logic [AW-1:0] wp_r;
    logic [CW-1:0] cnt_r;
    logic [FW-1:0] flash_r;
    logic          ovf_r;
    logic [7:0]    show_r;
    logic          blank_r;
    logic [AW-1:0] rd_idx_s;
    logic          accept_s;

    assign accept_s = ch_valid[i] & ~freeze & ~clear;
    assign rd_idx_s = wp_r - AW'(1) - hist_sel;

    // Pointer, fill count, sticky overflow and flash timer; clear beats a strobe.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wp_r    <= {AW{1'b0}};
        cnt_r   <= {CW{1'b0}};
        flash_r <= {FW{1'b0}};
        ovf_r   <= 1'b0;
      end else if (clear) begin
        wp_r    <= {AW{1'b0}};
        cnt_r   <= {CW{1'b0}};
        flash_r <= {FW{1'b0}};
        ovf_r   <= 1'b0;
      end else if (accept_s) begin
        wp_r    <= wp_r + AW'(1);
        flash_r <= FW'(FLASH_TICKS);
        if (cnt_r == CW'(DEPTH)) begin
          ovf_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else if (tick_s && (flash_r != {FW{1'b0}})) begin
        flash_r <= flash_r - FW'(1);
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k < DEPTH; k++) buf_r[k] <= 8'h00;
      end else if (accept_s) begin
        buf_r[wp_r] <= ch_data[8*i +: 8];
      end
    end

    // History selection; an index beyond the fill count blanks the channel.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        show_r  <= 8'h00;
        blank_r <= 1'b1;
      end else if (CW'(hist_sel) < cnt_r) begin
        show_r  <= buf_r[rd_idx_s];
        blank_r <= 1'b0;
      end else begin
        blank_r <= 1'b1;
      end
    end

    assign show_s[i]     = show_r;
    assign blank_s[i]    = blank_r;
    assign flash_on_s[i] = (flash_r != {FW{1'b0}});
    assign overflow[i]   = ovf_r;
  end

  always_comb begin
    sel_ch_s = CHW'(scan_nxt_s >> 1);
    if (scan_nxt_s[0]) begin
      nib_s = show_s[sel_ch_s][7:4];
    end else begin
      nib_s = show_s[sel_ch_s][3:0];
    end
  end

  // Scan index and display registers advance together on each refresh tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_r <= {SW{1'b0}};
      an     <= {ND{1'b1}};
      seg    <= 7'h7F;
      dp     <= 1'b1;
    end else if (tick_s) begin
      scan_r <= scan_nxt_s;
      an     <= ~(ND'(1) << scan_nxt_s);
      seg    <= blank_s[sel_ch_s] ? 7'h7F : hex7(nib_s);
      dp     <= ~(~scan_nxt_s[0] & flash_on_s[sel_ch_s]);
    end
  end

endmodule

// File: tb/tb_seg_byte_monitor.sv
// Directed bench for seg_byte_monitor with NUM_CH=2, DEPTH=4, DIV=4, FLASH_TICKS=3.
module tb_seg_byte_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ch_valid;
  logic [15:0] ch_data;
  logic [1:0]  hist_sel;
  logic        freeze;
  logic        clear;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  overflow;

  int vec_cnt    = 0;
  int miscmp_cnt = 0;
  int cyc        = 0;
  int ticks      = 0;

  seg_byte_monitor #(.NUM_CH(2), .DEPTH(4), .DIV(4), .FLASH_TICKS(3)) dut (
    .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_data(ch_data),
    .hist_sel(hist_sel), .freeze(freeze), .clear(clear),
    .seg(seg), .dp(dp), .an(an), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock; every DIV=4 edges after reset release is a refresh tick.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc % 4 == 0) ticks++;
  endtask

  task automatic to_digit(input int d);
    int  n   = 0;
    bit  hit = 1'b0;
    while (!hit && n < 64) begin
      step();
      n++;
      hit = (cyc % 4 == 0) && (ticks % 4 == d);
    end
    if (!hit) check_vec("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic show(input string tag, input int d, input logic [6:0] s, input logic p);
    logic [3:0] e;
    to_digit(d);
    e    = 4'hF;
    e[d] = 1'b0;
    check_vec({tag, "_an"}, an, e);
    check_vec({tag, "_seg"}, seg, s);
    check_vec({tag, "_dp"}, dp, p);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) to_digit((ticks + 1) % 4);
  endtask

  task automatic strobe(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1);
    ch_valid = v;
    ch_data  = {d1, d0};
    step();
    ch_valid = 2'b00;
    ch_data  = 16'h0000;
  endtask

  initial begin
    reset    = 1'b0;
    ch_valid = 2'b00;
    ch_data  = 16'h0000;
    hist_sel = 2'd0;
    freeze   = 1'b0;
    clear    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_vec("rst_an", an, 4'hF);
    check_vec("rst_seg", seg, 7'h7F);
    check_vec("rst_dp", dp, 1'b1);
    check_vec("rst_ovf", overflow, 2'b00);
    reset = 1'b1;
    step();
    step();
    check_vec("pre_tick_an", an, 4'hF);

    // 1: idle scan, every digit blank
    for (int k = 0; k < 8; k++) show("idle", (ticks + 1) % 4, 7'h7F, 1'b1);
    check_vec("idle_ovf", overflow, 2'b00);

    // 2: single byte A5 on ch0, flash visible on an0 only while the timer runs
    to_digit(3);
    strobe(2'b01, 8'hA5, 8'h00);
    show("a5_lo", 0, 7'h12, 1'b0);
    show("a5_hi", 1, 7'h08, 1'b1);
    show("a5_c1lo", 2, 7'h7F, 1'b1);
    show("a5_c1hi", 3, 7'h7F, 1'b1);
    show("a5_lo_noflash", 0, 7'h12, 1'b1);

    // 3: five bytes into a 4-deep buffer
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_vec("clr_ovf", overflow, 2'b00);
    strobe(2'b01, 8'h11, 8'h00);
    strobe(2'b01, 8'h22, 8'h00);
    strobe(2'b01, 8'h33, 8'h00);
    strobe(2'b01, 8'h44, 8'h00);
    check_vec("ovf_after4", overflow, 2'b00);
    strobe(2'b01, 8'h55, 8'h00);
    check_vec("ovf_after5", overflow, 2'b01);
    wait_ticks(4);
    show("h0_lo", 0, 7'h12, 1'b1);
    show("h0_hi", 1, 7'h12, 1'b1);
    hist_sel = 2'd3;
    show("h3_lo", 0, 7'h24, 1'b1);
    show("h3_hi", 1, 7'h24, 1'b1);

    // 4: partially filled ch1
    strobe(2'b10, 8'h00, 8'h01);
    strobe(2'b10, 8'h00, 8'h02);
    wait_ticks(4);
    hist_sel = 2'd2;
    show("c1h2_lo", 2, 7'h7F, 1'b1);
    show("c1h2_hi", 3, 7'h7F, 1'b1);
    show("c0h2_lo", 0, 7'h30, 1'b1);
    hist_sel = 2'd1;
    show("c1h1_lo", 2, 7'h79, 1'b1);
    show("c1h1_hi", 3, 7'h40, 1'b1);
    show("c0h1_lo", 0, 7'h19, 1'b1);

    // 5: freeze drops the byte, clear wipes both channels and beats a strobe
    hist_sel = 2'd0;
    to_digit(3);
    freeze = 1'b1;
    strobe(2'b01, 8'hFF, 8'h00);
    freeze = 1'b0;
    show("frz_lo", 0, 7'h12, 1'b1);
    show("frz_hi", 1, 7'h12, 1'b1);
    check_vec("frz_ovf", overflow, 2'b01);
    clear    = 1'b1;
    ch_valid = 2'b10;
    ch_data  = 16'h7700;
    step();
    clear    = 1'b0;
    ch_valid = 2'b00;
    ch_data  = 16'h0000;
    check_vec("clr2_ovf", overflow, 2'b00);
    show("clr_d2", 2, 7'h7F, 1'b1);
    show("clr_d3", 3, 7'h7F, 1'b1);
    show("clr_d0", 0, 7'h7F, 1'b1);
    show("clr_d1", 1, 7'h7F, 1'b1);

    // 6: simultaneous strobes on both channels
    to_digit(3);
    strobe(2'b11, 8'h3C, 8'hC3);
    show("both_d0", 0, 7'h46, 1'b0);
    show("both_d1", 1, 7'h30, 1'b1);
    show("both_d2", 2, 7'h30, 1'b0);
    show("both_d3", 3, 7'h46, 1'b1);
    show("both_d0_late", 0, 7'h46, 1'b1);
    check_vec("both_ovf", overflow, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
